// File: rtl/scratch_fill_controller.sv
// Fill controller for the filter and IF scratchpads: accepts words from two valid/ready
// streams, writes them with one cycle of latency, and publishes write pointers for the read checker.
module scratch_fill_controller #(
    parameter int IF_CELL_SIZE        = 8,
    parameter int IF_ADDRESS_SIZE     = 8,
    parameter int FILTER_CELL_SIZE    = 8,
    parameter int FILTER_ADDRESS_SIZE = 8,
    parameter int CELL_NUMS_IF        = 8,
    parameter int CELL_NUMS_FILTER    = 8
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    input  logic [2:0]                     filter_size,
    input  logic [FILTER_CELL_SIZE-1:0]    filter_data_in,
    input  logic                           filter_valid,
    output logic                           filter_ready,
    input  logic [IF_CELL_SIZE-1:0]        if_data_in,
    input  logic                           if_valid,
    input  logic                           if_last,
    output logic                           if_ready,
    input  logic [IF_ADDRESS_SIZE-1:0]     read_start_if,
    input  logic                           conv_done,
    output logic                           filter_wen,
    output logic [FILTER_ADDRESS_SIZE-1:0] filter_waddr,
    output logic [FILTER_CELL_SIZE-1:0]    filter_wdata,
    output logic                           if_wen,
    output logic [IF_ADDRESS_SIZE-1:0]     if_waddr,
    output logic [IF_CELL_SIZE-1:0]        if_wdata,
    output logic [FILTER_ADDRESS_SIZE-1:0] write_addr_filter,
    output logic [IF_ADDRESS_SIZE-1:0]     write_addr_if,
    output logic                           inner_start,
    output logic                           if_full,
    output logic                           fill_done
);

    // One extra bit so wptr + depth cannot overflow when the depth is a full power of two.
    localparam int OW = IF_ADDRESS_SIZE + 1;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_FILTER,
        LOAD_IF,
        STREAM,
        DRAIN
    } state_t;

    state_t state, state_nx;

    logic [2:0]                     fsize_q;
    logic [OW-1:0]                  wptr_ext;
    logic [OW-1:0]                  rs_ext;
    logic [OW-1:0]                  occ;
    logic [OW-1:0]                  occ_post;
    logic                           occ_full;
    logic                           if_phase;
    logic                           filter_acc;
    logic                           if_acc;
    logic [IF_ADDRESS_SIZE-1:0]     wptr_if_nx;
    logic [FILTER_ADDRESS_SIZE-1:0] wptr_filter_nx;
    logic                           inner_start_nx;
    logic                           fill_done_nx;
    logic                           clr_ptrs;

    assign wptr_ext = {1'b0, write_addr_if};
    assign rs_ext   = {1'b0, read_start_if};
    assign occ      = (wptr_ext >= rs_ext) ? (wptr_ext - rs_ext)
                                           : (wptr_ext + OW'(CELL_NUMS_IF) - rs_ext);
    assign occ_post = occ + OW'(1);
    // One cell stays empty so a full buffer never looks like an empty one to the checker.
    assign occ_full = (occ == OW'(CELL_NUMS_IF - 1));

    assign if_phase     = (state == LOAD_IF) || (state == STREAM);
    assign if_full      = if_phase && occ_full;
    assign if_ready     = if_phase && !occ_full;
    assign filter_ready = (state == LOAD_FILTER);

    assign filter_acc = filter_valid && filter_ready;
    assign if_acc     = if_valid && if_ready;

    assign wptr_if_nx = (write_addr_if == IF_ADDRESS_SIZE'(CELL_NUMS_IF - 1))
                      ? '0 : write_addr_if + IF_ADDRESS_SIZE'(1);
    assign wptr_filter_nx = (write_addr_filter == FILTER_ADDRESS_SIZE'(CELL_NUMS_FILTER - 1))
                          ? '0 : write_addr_filter + FILTER_ADDRESS_SIZE'(1);

    always_comb begin
        state_nx       = state;
        inner_start_nx = 1'b0;
        fill_done_nx   = 1'b0;
        clr_ptrs       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    clr_ptrs = 1'b1;
                    state_nx = (filter_size != 3'd0) ? LOAD_FILTER : LOAD_IF;
                end
            end
            LOAD_FILTER: begin
                if (filter_acc && (wptr_filter_nx == FILTER_ADDRESS_SIZE'(fsize_q)))
                    state_nx = LOAD_IF;
            end
            LOAD_IF: begin
                // The start pulse lands with the qualifying word's wen, so that word is resident.
                if (if_acc) begin
                    if (if_last) begin
                        state_nx       = DRAIN;
                        inner_start_nx = 1'b1;
                    end else if (occ_post >= OW'(fsize_q)) begin
                        state_nx       = STREAM;
                        inner_start_nx = 1'b1;
                    end
                end
            end
            STREAM: begin
                if (if_acc && if_last)
                    state_nx = DRAIN;
            end
            DRAIN: begin
                if (conv_done) begin
                    state_nx     = IDLE;
                    fill_done_nx = 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state             <= IDLE;
            fsize_q           <= '0;
            write_addr_filter <= '0;
            write_addr_if     <= '0;
            filter_wen        <= 1'b0;
            filter_waddr      <= '0;
            filter_wdata      <= '0;
            if_wen            <= 1'b0;
            if_waddr          <= '0;
            if_wdata          <= '0;
            inner_start       <= 1'b0;
            fill_done         <= 1'b0;
        end else begin
            state       <= state_nx;
            inner_start <= inner_start_nx;
            fill_done   <= fill_done_nx;
            filter_wen  <= filter_acc;
            if_wen      <= if_acc;
            if (clr_ptrs) begin
                write_addr_filter <= '0;
                write_addr_if     <= '0;
                fsize_q           <= filter_size;
            end else begin
                if (filter_acc) write_addr_filter <= wptr_filter_nx;
                if (if_acc)     write_addr_if     <= wptr_if_nx;
            end
            if (filter_acc) begin
                filter_waddr <= write_addr_filter;
                filter_wdata <= filter_data_in;
            end
            if (if_acc) begin
                if_waddr <= write_addr_if;
                if_wdata <= if_data_in;
            end
        end
    end

endmodule

// File: tb/tb_scratch_fill_controller.sv
// Randomized bench for scratch_fill_controller; expectations come from a word-count model
// (words written vs. words released by the reader) rather than pointer arithmetic.
module tb_scratch_fill_controller;

    localparam int N = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [2:0] filter_size;
    logic [7:0] filter_data_in;
    logic       filter_valid;
    logic       filter_ready;
    logic [7:0] if_data_in;
    logic       if_valid;
    logic       if_last;
    logic       if_ready;
    logic [7:0] read_start_if;
    logic       conv_done;
    logic       filter_wen;
    logic [7:0] filter_waddr;
    logic [7:0] filter_wdata;
    logic       if_wen;
    logic [7:0] if_waddr;
    logic [7:0] if_wdata;
    logic [7:0] write_addr_filter;
    logic [7:0] write_addr_if;
    logic       inner_start;
    logic       if_full;
    logic       fill_done;

    always #5 clk = ~clk;

    scratch_fill_controller #(
        .IF_CELL_SIZE(8), .IF_ADDRESS_SIZE(8), .FILTER_CELL_SIZE(8),
        .FILTER_ADDRESS_SIZE(8), .CELL_NUMS_IF(N), .CELL_NUMS_FILTER(8)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .filter_size(filter_size),
        .filter_data_in(filter_data_in), .filter_valid(filter_valid), .filter_ready(filter_ready),
        .if_data_in(if_data_in), .if_valid(if_valid), .if_last(if_last), .if_ready(if_ready),
        .read_start_if(read_start_if), .conv_done(conv_done),
        .filter_wen(filter_wen), .filter_waddr(filter_waddr), .filter_wdata(filter_wdata),
        .if_wen(if_wen), .if_waddr(if_waddr), .if_wdata(if_wdata),
        .write_addr_filter(write_addr_filter), .write_addr_if(write_addr_if),
        .inner_start(inner_start), .if_full(if_full), .fill_done(fill_done)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Model: phase 0 idle, 1 filter load, 2 IF load, 3 stream, 4 drain.
    int phase, fs, nf, ni, nrd, rd_pct;
    int e_fwaddr, e_fwdata, e_iwaddr, e_iwdata;
    logic e_fwen, e_iwen, e_inner, e_done;
    logic e_fr, e_ir, e_full, fa, ia;
    int n_full_seen, n_inner_seen, n_done_seen;

    task automatic model_reset();
        phase = 0; fs = 0; nf = 0; ni = 0; nrd = 0; rd_pct = 50;
        e_fwen = 0; e_iwen = 0; e_inner = 0; e_done = 0;
        e_fwaddr = 0; e_fwdata = 0; e_iwaddr = 0; e_iwdata = 0;
    endtask

    initial begin
        int step;
        model_reset();
        n_full_seen = 0; n_inner_seen = 0; n_done_seen = 0;
        rst = 1'b1; start = 0; filter_size = 0; filter_data_in = 0; filter_valid = 0;
        if_data_in = 0; if_valid = 0; if_last = 0; read_start_if = 0; conv_done = 0;

        for (int cyc = 0; cyc < 6000; cyc++) begin
            @(negedge clk);
            rst            = (cyc < 2) || (phase == 3 && $urandom_range(0, 59) == 0);
            start          = ($urandom_range(0, 3) == 0);
            filter_size    = 3'($urandom_range(0, 7));
            filter_valid   = ($urandom_range(0, 3) != 0);
            filter_data_in = 8'($urandom);
            if_valid       = ($urandom_range(0, 3) != 0);
            if_data_in     = 8'($urandom);
            if_last        = ($urandom_range(0, 24) == 0);
            conv_done      = ($urandom_range(0, 3) == 0);
            // The reader releases words it has consumed; it can never pass the writer.
            if (phase >= 2 && ni > nrd && $urandom_range(0, 99) < rd_pct) begin
                step = (ni - nrd > 1) ? $urandom_range(1, 2) : 1;
                nrd += step;
            end
            read_start_if = 8'(nrd % N);
            #1;
            e_fr   = (phase == 1);
            e_ir   = (phase == 2 || phase == 3) && (ni - nrd) < N - 1;
            e_full = (phase == 2 || phase == 3) && (ni - nrd) == N - 1;
            if (cyc >= 2) begin
                chk("filter_ready", filter_ready, e_fr);
                chk("if_ready", if_ready, e_ir);
                chk("if_full", if_full, e_full);
            end
            if (e_full) n_full_seen++;
            fa = filter_valid && e_fr;
            ia = if_valid && e_ir;

            @(posedge clk);
            if (rst) begin
                model_reset();
            end else begin
                e_fwen = fa; e_iwen = ia; e_inner = 0; e_done = 0;
                if (fa) begin e_fwaddr = nf; e_fwdata = filter_data_in; nf++; end
                if (ia) begin e_iwaddr = ni % N; e_iwdata = if_data_in; ni++; end
                case (phase)
                    0: if (start) begin
                        nf = 0; ni = 0; nrd = 0; fs = filter_size;
                        phase = (fs != 0) ? 1 : 2;
                        case ($urandom_range(0, 2))
                            0: rd_pct = 5;
                            1: rd_pct = 50;
                            default: rd_pct = 90;
                        endcase
                    end
                    1: if (fa && nf == fs) phase = 2;
                    2: if (ia) begin
                        if (if_last) begin phase = 4; e_inner = 1; end
                        else if (ni - nrd >= fs) begin phase = 3; e_inner = 1; end
                    end
                    3: if (ia && if_last) phase = 4;
                    4: if (conv_done) begin phase = 0; e_done = 1; end
                    default: phase = 0;
                endcase
            end
            #1;
            chk("filter_wen", filter_wen, e_fwen);
            chk("filter_waddr", filter_waddr, e_fwaddr);
            chk("filter_wdata", filter_wdata, e_fwdata);
            chk("if_wen", if_wen, e_iwen);
            chk("if_waddr", if_waddr, e_iwaddr);
            chk("if_wdata", if_wdata, e_iwdata);
            chk("write_addr_filter", write_addr_filter, nf);
            chk("write_addr_if", write_addr_if, ni % N);
            chk("inner_start", inner_start, e_inner);
            chk("fill_done", fill_done, e_done);
            if (e_inner) n_inner_seen++;
            if (e_done) n_done_seen++;
        end

        // The random run must actually have reached the full, start and finish conditions.
        chk("full_reached", n_full_seen > 0, 1'b1);
        chk("inner_start_reached", n_inner_seen > 0, 1'b1);
        chk("fill_done_reached", n_done_seen > 0, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
